slave_reg: RTL

- Bus target stage directly downstream of the bus master: accepts the master's two-phase (address phase, then data phase) transactions.
- Backs them with a small bank of 32-bit registers.
- Drives ready, read_data and an error flag back to the master.
- Adds programmable data-phase wait states so master stall handling can be exercised.

---
 rtl/slave_reg.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/slave_reg.sv
// Bus target: two-phase (address, data) handshake onto a bank of 32-bit registers
// with programmable data-phase wait states. Optional macro SLAVE_REG_RO_ID_EN makes register 0 a read-only ID.
module slave_reg #(
  parameter int unsigned NUM_REGS    = 8,
  parameter logic [15:0] BASE_ADDR   = 16'h0000,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h5A5A_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [31:0] write_data,
  output logic        ready,
  output logic [31:0] read_data,
  output logic        err
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ADDR_ACK  = 2'd1;
  localparam logic [1:0] ST_DATA_WAIT = 2'd2;
  localparam logic [1:0] ST_DATA_ACK  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] idx_q, idx_d;
  logic        wr_q, wr_d;
  logic        hit_q, hit_d;
  logic        ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] regs_q [NUM_REGS];

  logic [15:0] idx_dec;
  logic        hit_dec;
  logic        malformed;
  logic        data_ack_d;
  logic        ro_hit;
  logic        access_ok;
  logic        we;
  logic [31:0] rd_mux;

  assign idx_dec = addr - BASE_ADDR;
  assign hit_dec = (addr >= BASE_ADDR) && ({1'b0, idx_dec} < 17'(NUM_REGS));

`ifdef SLAVE_REG_RO_ID_EN
  assign ro_hit = (idx_q == 16'd0);
`else
  logic [31:0] unused_id;
  assign ro_hit    = 1'b0;
  assign unused_id = ID_VALUE;
`endif

  always_comb begin
    rd_mux = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (idx_q == 16'(i)) rd_mux = regs_q[i];
    end
`ifdef SLAVE_REG_RO_ID_EN
    if (ro_hit) rd_mux = ID_VALUE;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    hit_d     = hit_q;
    malformed = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (valid && (read ^ write)) begin
          idx_d   = idx_dec;
          wr_d    = write;
          hit_d   = hit_dec;
          state_d = ST_ADDR_ACK;
        end else if (valid && read && write) begin
          malformed = 1'b1;
        end
      end
      ST_ADDR_ACK: begin
        cnt_d = 8'(WAIT_CYCLES);
        if (!valid)                state_d = ST_IDLE;
        else if (WAIT_CYCLES == 0) state_d = ST_DATA_ACK;
        else                       state_d = ST_DATA_WAIT;
      end
      ST_DATA_WAIT: begin
        cnt_d = cnt_q - 8'd1;
        if (!valid)             state_d = ST_IDLE;
        else if (cnt_q == 8'd1) state_d = ST_DATA_ACK;
      end
      ST_DATA_ACK: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so ready/read_data/err line up
  // with the cycle the FSM spends in each ack state; the write commits on the same edge.
  assign data_ack_d = (state_d == ST_DATA_ACK);
  assign access_ok  = hit_q && !(wr_q && ro_hit);
  assign we         = data_ack_d && wr_q && access_ok;

  always_comb begin
    ready_d = (state_d == ST_ADDR_ACK) || data_ack_d;
    rdata_d = (data_ack_d && !wr_q && access_ok) ? rd_mux : '0;
    err_d   = malformed || (data_ack_d && !access_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (idx_q == 16'(i)) regs_q[i] <= write_data;
      end
    end
  end

  assign ready     = ready_q;
  assign read_data = rdata_q;
  assign err       = err_q;

endmodule
